// File: rtl/percept_seq.sv
// percept_seq: host-serial operand sequencer for the percept neuron.
// Loads weight/input pairs, fires one MAC per pair, unloads the result.
module percept_seq #(
  parameter int N_INPUTS     = 8,
  parameter int WIDTH        = 8,
  parameter int RESULT_WIDTH = 16
) (
  input  logic clk,
  input  logic nRst,
  input  logic start,
  input  logic abort,
  input  logic op_valid,
  input  logic op_bit,
  output logic op_ready,
  output logic res_valid,
  output logic res_bit,
  output logic busy,
  output logic done,
  output logic p_shift_in,
  output logic p_data_in,
  output logic p_mul_and_acc,
  output logic p_shift_out,
  input  logic p_data_out
);

  localparam int BW = $clog2(2 * WIDTH);
  localparam int PW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int UW = $clog2(RESULT_WIDTH + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(2 * WIDTH - 1);
  localparam logic [PW-1:0] PAIR_LAST = PW'(N_INPUTS - 1);
  localparam logic [UW-1:0] U_LAST    = UW'(RESULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC,
    UNLOAD
  } state_t;

  state_t          state;
  logic [BW-1:0]   bit_cnt;
  logic [PW-1:0]   pair_cnt;
  logic [UW-1:0]   u_cnt;
  logic            accept;

  assign accept = op_valid & op_ready;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      pair_cnt      <= '0;
      u_cnt         <= '0;
      op_ready      <= 1'b0;
      res_valid     <= 1'b0;
      res_bit       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      p_shift_in    <= 1'b0;
      p_data_in     <= 1'b0;
      p_mul_and_acc <= 1'b0;
      p_shift_out   <= 1'b0;
    end else if (abort) begin
      // Pending strobes are dropped too; percept is left dirty.
      state         <= IDLE;
      bit_cnt       <= '0;
      pair_cnt      <= '0;
      u_cnt         <= '0;
      op_ready      <= 1'b0;
      res_valid     <= 1'b0;
      res_bit       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      p_shift_in    <= 1'b0;
      p_data_in     <= 1'b0;
      p_mul_and_acc <= 1'b0;
      p_shift_out   <= 1'b0;
    end else begin
      p_shift_in    <= 1'b0;
      p_mul_and_acc <= 1'b0;
      res_valid     <= 1'b0;
      done          <= 1'b0;
      unique case (state)
        IDLE: begin
          bit_cnt  <= '0;
          pair_cnt <= '0;
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            op_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            p_shift_in <= 1'b1;
            p_data_in  <= op_bit;
            if (bit_cnt == BIT_LAST) begin
              state    <= MAC;
              op_ready <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        MAC: begin
          p_mul_and_acc <= 1'b1;
          if (pair_cnt == PAIR_LAST) begin
            state <= UNLOAD;
            u_cnt <= '0;
          end else begin
            pair_cnt <= pair_cnt + 1'b1;
            bit_cnt  <= '0;
            state    <= LOAD;
            op_ready <= 1'b1;
          end
        end
        UNLOAD: begin
          // u0 only arms shift_out; result bits follow one edge later.
          if (u_cnt != '0) begin
            res_bit   <= p_data_out;
            res_valid <= 1'b1;
          end
          if (u_cnt == U_LAST) begin
            p_shift_out <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            p_shift_out <= 1'b1;
            u_cnt       <= u_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_percept_seq.sv
// tb_percept_seq: randomized scoreboard bench for percept_seq.
// Two configurations, each wired to a behavioural percept model.
`timescale 1ns/1ps
module tb_percept_seq;

  typedef struct {
    int     inst;
    longint res;
    int     macs;
    int     shins;
    int     nres;
    int     lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       nRst;
  logic [1:0] start, abort, op_valid, op_bit;
  logic [1:0] op_ready, res_valid, res_bit, busy, done;
  logic [1:0] psi, pdi, pma, pso, pdo;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic int cfg_n(input int i);
    return (i == 0) ? 8 : 2;
  endfunction
  function automatic int cfg_w(input int i);
    return (i == 0) ? 8 : 4;
  endfunction
  function automatic int cfg_r(input int i);
    return (i == 0) ? 16 : 8;
  endfunction

  function automatic logic [8:0] outs(input int i);
    return {op_ready[i], res_valid[i], res_bit[i],
            busy[i], done[i], psi[i], pdi[i],
            pma[i], pso[i]};
  endfunction

  task automatic chk(input bit ok, input string name,
                     input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h",
               name, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int N = (g == 0) ? 8 : 2;
    localparam int W = (g == 0) ? 8 : 4;
    localparam int R = (g == 0) ? 16 : 8;

    logic [2*W-1:0] sreg;
    logic [R-1:0]   acc;
    int             cyc, s_edge, macs, shins, nres;
    longint         res;
    bit             ptake, pbit;
    exp_t           e;

    percept_seq #(
      .N_INPUTS(N), .WIDTH(W), .RESULT_WIDTH(R)
    ) dut (
      .clk(clk), .nRst(nRst),
      .start(start[g]), .abort(abort[g]),
      .op_valid(op_valid[g]), .op_bit(op_bit[g]),
      .op_ready(op_ready[g]),
      .res_valid(res_valid[g]), .res_bit(res_bit[g]),
      .busy(busy[g]), .done(done[g]),
      .p_shift_in(psi[g]), .p_data_in(pdi[g]),
      .p_mul_and_acc(pma[g]), .p_shift_out(pso[g]),
      .p_data_out(pdo[g])
    );

    always @(posedge clk or negedge nRst) begin
      if (!nRst) begin
        sreg <= '0;
        acc  <= '0;
      end else if (psi[g]) begin
        sreg <= {sreg[2*W-2:0], pdi[g]};
      end else if (pma[g]) begin
        acc <= R'(longint'(acc) +
                  longint'(sreg[2*W-1:W]) *
                  longint'(sreg[W-1:0]));
      end else if (pso[g]) begin
        acc <= {acc[R-2:0], 1'b0};
      end
    end
    assign pdo[g] = acc[R-1];

    always @(negedge clk) begin
      if (!nRst) begin
        cyc = 0; s_edge = 0; ptake = 0; pbit = 0;
        macs = 0; shins = 0; nres = 0; res = 0;
      end else begin
        cyc++;
        chk($countones({psi[g], pma[g], pso[g]}) <= 1,
            "strobe_excl", {psi[g], pma[g], pso[g]}, 0);
        chk(!(op_ready[g] &&
              (!busy[g] || pso[g] || res_valid[g])),
            "ready_outside_load", op_ready[g], 0);
        if (psi[g] || ptake)
          chk(psi[g] == ptake &&
              (!psi[g] || pdi[g] == pbit),
              "shift_in_after_accept",
              {psi[g], pdi[g]}, {ptake, pbit});
        if (pma[g]) macs++;
        if (psi[g]) shins++;
        if (res_valid[g]) begin
          res = (res << 1) | longint'(res_bit[g]);
          nres++;
        end
        if (done[g]) begin
          chk(exp_q.size() > 0, "unexpected_done",
              exp_q.size(), 1);
          chk(res_valid[g], "done_last_bit", res_valid[g], 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.inst == g, "done_inst", g, e.inst);
            chk(res == e.res, "result", res, e.res);
            chk(macs == e.macs, "mac_count", macs, e.macs);
            chk(shins == e.shins, "shift_in_count",
                shins, e.shins);
            chk(nres == e.nres, "res_bits", nres, e.nres);
            if (e.lat >= 0)
              chk(cyc - s_edge == e.lat, "done_latency",
                  cyc - s_edge, e.lat);
          end
        end
        ptake = op_valid[g] && op_ready[g] && !abort[g];
        pbit  = op_bit[g];
        if (abort[g] || (start[g] && !busy[g])) begin
          s_edge = cyc + 1;
          macs = 0; shins = 0; nres = 0; res = 0;
        end
      end
    end
  end

  // kind: 0 full pass, 1 abort at bit abort_idx, 2 reset mid-unload
  task automatic run_pass(input int i, input int vmode,
                          input bit spam, input int kind,
                          input int abort_idx, input bit directed);
    int     n, w, r, wv, xv, idx, guard, cnt;
    bit     bits[$];
    bit     take, ph, seen;
    longint sum, mask;
    exp_t   ex;
    n = cfg_n(i); w = cfg_w(i); r = cfg_r(i);
    sum = 0;
    mask = (longint'(1) << r) - 1;
    for (int p = 0; p < n; p++) begin
      wv = directed ? 1 : int'($urandom_range((1 << w) - 1));
      xv = directed ? 2 : int'($urandom_range((1 << w) - 1));
      sum += longint'(wv) * longint'(xv);
      for (int b = w - 1; b >= 0; b--)
        bits.push_back(bit'((wv >> b) & 1));
      for (int b = w - 1; b >= 0; b--)
        bits.push_back(bit'((xv >> b) & 1));
    end
    if (kind == 0) begin
      ex.inst = i; ex.res = sum & mask; ex.macs = n;
      ex.shins = 2 * w * n; ex.nres = r;
      ex.lat = (vmode == 0) ? n * (2 * w + 1) + 1 + r : -1;
      exp_q.push_back(ex);
    end
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
    idx = 0; guard = 0; ph = 1'b1;
    while (idx < bits.size() && guard < 2000) begin
      if (kind == 1 && idx == abort_idx) break;
      case (vmode)
        0: op_valid[i] = 1'b1;
        1: begin op_valid[i] = ph; ph = ~ph; end
        default: op_valid[i] = 1'($urandom_range(1));
      endcase
      op_bit[i] = bits[idx];
      start[i] = spam ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
      if (guard == 0)
        chk(op_ready[i] && busy[i], "ready_after_start",
            {op_ready[i], busy[i]}, 2'b11);
      take = op_valid[i] && op_ready[i];
      @(posedge clk); #1;
      if (take) idx++;
      guard++;
    end
    op_valid[i] = 1'b0;
    start[i] = 1'b0;
    chk(guard < 2000, "load_timeout", guard, 2000);
    if (kind == 1) begin
      abort[i] = 1'b1;
      @(posedge clk); #1 abort[i] = 1'b0;
      @(negedge clk);
      chk(outs(i) == 0, "abort_outputs", outs(i), 0);
      cnt = 0;
      repeat (40) begin
        @(negedge clk);
        if (done[i] || busy[i]) cnt++;
      end
      chk(cnt == 0, "abort_no_done", cnt, 0);
    end else if (kind == 2) begin
      cnt = 0; guard = 0;
      while (cnt < 3 && guard < 400) begin
        @(negedge clk);
        if (res_valid[i]) cnt++;
        guard++;
      end
      chk(cnt == 3, "unload_reached", cnt, 3);
      #2 nRst = 1'b0;
      #1 chk(outs(i) == 0, "reset_async", outs(i), 0);
      @(posedge clk); @(posedge clk); #1 nRst = 1'b1;
      cnt = 0;
      repeat (20) begin
        @(negedge clk);
        if (res_valid[i]) cnt++;
      end
      chk(cnt == 0, "res_after_reset", cnt, 0);
    end else begin
      seen = 1'b0; guard = 0;
      while (!seen && guard < 400) begin
        @(negedge clk);
        if (done[i]) seen = 1'b1;
        else begin
          @(posedge clk); #1;
          start[i] = (spam && busy[i]) ?
                     1'($urandom_range(1)) : 1'b0;
        end
        guard++;
      end
      start[i] = 1'b0;
      chk(seen, "done_timeout", guard, 400);
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    nRst = 1'b0;
    start = '0; abort = '0; op_valid = '0; op_bit = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk(outs(i) == 0, "reset_outputs", outs(i), 0);
    @(posedge clk); #1 nRst = 1'b1;
    run_pass(0, 0, 1'b0, 0, 0, 1'b1);
    run_pass(1, 1, 1'b0, 0, 0, 1'b0);
    run_pass(1, 1, 1'b0, 0, 0, 1'b0);
    run_pass(0, 0, 1'b1, 0, 0, 1'b0);
    run_pass(0, 2, 1'b0, 0, 0, 1'b0);
    run_pass(1, 2, 1'b1, 0, 0, 1'b0);
    run_pass(0, 0, 1'b0, 1, 2 * 16 + 5, 1'b0);
    @(posedge clk); #1 nRst = 1'b0;
    @(posedge clk); #1 nRst = 1'b1;
    run_pass(0, 0, 1'b0, 0, 0, 1'b0);
    run_pass(1, 0, 1'b0, 2, 0, 1'b0);
    run_pass(1, 0, 1'b0, 0, 0, 1'b0);
    run_pass(1, 1, 1'b1, 0, 0, 1'b0);
    repeat (5) @(posedge clk);
    chk(exp_q.size() == 0, "pending_expect", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
